// File: rtl/nios2_dct_packer_if.sv
// Symbol-intake / frame-output / end-of-test bundle between the DCT packer and its trace sink.
interface nios2_dct_packer_if #(
   parameter int unsigned SYM_W = 2,
   parameter int unsigned SLOTS = 15
);
   localparam int unsigned BUF_W = SYM_W * SLOTS;
   localparam int unsigned CNT_W = $clog2(SLOTS + 1);

   logic             sym_valid;
   logic [SYM_W-1:0] sym_data;
   logic             sym_ready;
   logic             flush;
   logic             end_req;
   logic [BUF_W-1:0] dct_buffer;
   logic [CNT_W-1:0] dct_count;
   logic             out_valid;
   logic             out_ready;
   logic             test_ending;
   logic             test_has_ended;

   // Packer side: consumes symbols, produces frames and end-of-test status.
   modport master (
      input  sym_valid,
      input  sym_data,
      output sym_ready,
      input  flush,
      input  end_req,
      output dct_buffer,
      output dct_count,
      output out_valid,
      input  out_ready,
      output test_ending,
      output test_has_ended
   );

   // Trace logic + sink side.
   modport slave (
      output sym_valid,
      output sym_data,
      input  sym_ready,
      output flush,
      output end_req,
      input  dct_buffer,
      input  dct_count,
      input  out_valid,
      output out_ready,
      input  test_ending,
      input  test_has_ended
   );
endinterface

// File: rtl/nios2_dct_packer.sv
// Packs 2-bit trace symbols into 15-slot frames behind a double buffer (accumulator + output
// register) and sequences the end-of-test drain handshake toward the trace sink.
module nios2_dct_packer #(
   parameter int unsigned SYM_W = 2,
   parameter int unsigned SLOTS = 15
) (
   input  logic                clk,
   input  logic                reset_n,
   nios2_dct_packer_if.master  bus
);
   localparam int unsigned BUF_W = SYM_W * SLOTS;
   localparam int unsigned CNT_W = $clog2(SLOTS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_ENDED = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [BUF_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_pend_q, flush_pend_d;
   logic [BUF_W-1:0] dct_buffer_q, dct_buffer_d;
   logic [CNT_W-1:0] dct_count_q, dct_count_d;
   logic             out_valid_q, out_valid_d;
   logic             sym_ready_q, sym_ready_d;
   logic             test_ending_q, test_ending_d;
   logic             test_has_ended_q, test_has_ended_d;

   logic             accept;
   logic             out_free;
   logic             flush_req;
   logic             complete;
   logic [BUF_W-1:0] acc_upd;
   logic [CNT_W-1:0] cnt_upd;

   // Next-state: accumulator update, frame hand-off, flush bookkeeping and FSM.
   always_comb begin
      state_d          = state_q;
      acc_d            = acc_q;
      cnt_d            = cnt_q;
      flush_pend_d     = flush_pend_q;
      dct_buffer_d     = dct_buffer_q;
      dct_count_d      = dct_count_q;
      out_valid_d      = out_valid_q;
      acc_upd          = acc_q;
      cnt_upd          = cnt_q;

      accept   = bus.sym_valid && sym_ready_q;
      out_free = !out_valid_q || bus.out_ready;

      if (accept) begin
         acc_upd = {acc_q[BUF_W-SYM_W-1:0], bus.sym_data};
         cnt_upd = cnt_q + CNT_W'(1);
      end

      // DRAIN behaves as a standing flush so any residue is framed out.
      flush_req = flush_pend_q
               || (state_q == ST_DRAIN)
               || ((state_q == ST_RUN) && (bus.flush || bus.end_req));

      complete = (cnt_upd == CNT_FULL) || (flush_req && (cnt_upd != '0));

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (complete && out_free) begin
         dct_buffer_d = acc_upd;
         dct_count_d  = cnt_upd;
         out_valid_d  = 1'b1;
         acc_d        = '0;
         cnt_d        = '0;
         flush_pend_d = 1'b0;
      end else begin
         acc_d        = acc_upd;
         cnt_d        = cnt_upd;
         flush_pend_d = flush_req && (cnt_upd != '0);
      end

      case (state_q)
         ST_RUN: begin
            if (bus.end_req) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((cnt_q == '0) && !flush_pend_q && out_free) begin
               state_d = ST_ENDED;
            end
         end
         ST_ENDED: begin
            state_d = ST_ENDED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Status outputs are registered images of the next state.
      sym_ready_d      = (state_d == ST_RUN) && !flush_pend_d && (cnt_d != CNT_FULL);
      test_ending_d    = (state_d == ST_DRAIN);
      test_has_ended_d = (state_d == ST_ENDED);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= ST_RUN;
         acc_q            <= '0;
         cnt_q            <= '0;
         flush_pend_q     <= 1'b0;
         dct_buffer_q     <= '0;
         dct_count_q      <= '0;
         out_valid_q      <= 1'b0;
         sym_ready_q      <= 1'b1;
         test_ending_q    <= 1'b0;
         test_has_ended_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         acc_q            <= acc_d;
         cnt_q            <= cnt_d;
         flush_pend_q     <= flush_pend_d;
         dct_buffer_q     <= dct_buffer_d;
         dct_count_q      <= dct_count_d;
         out_valid_q      <= out_valid_d;
         sym_ready_q      <= sym_ready_d;
         test_ending_q    <= test_ending_d;
         test_has_ended_q <= test_has_ended_d;
      end
   end

   assign bus.sym_ready      = sym_ready_q;
   assign bus.dct_buffer     = dct_buffer_q;
   assign bus.dct_count      = dct_count_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.test_ending    = test_ending_q;
   assign bus.test_has_ended = test_has_ended_q;

endmodule
